// File: rtl/mealy_ozozo_pkg.sv
// rtl/mealy_ozozo_pkg.sv - shared types and helpers for the multiplexed 10101 detector
package mealy_ozozo_pkg;

  typedef enum logic [2:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4
  } state_e;

  localparam logic [4:0] PATTERN = 5'b10101;

  // Codes 5..7 cannot be produced by the step but are folded back to S0 defensively.
  function automatic state_e to_legal_state(input logic [2:0] raw);
    return (raw > 3'd4) ? S0 : state_e'(raw);
  endfunction

endpackage

// File: rtl/mealy_ozozo_step.sv
// rtl/mealy_ozozo_step.sv - combinational overlapping 10101 Mealy step
module mealy_ozozo_step
  import mealy_ozozo_pkg::*;
(
  input  logic [2:0] state_i,
  input  logic       bit_i,
  output logic [2:0] next_o,
  output logic       z_o
);

  state_e cur;
  state_e nxt;
  logic   match;

  // State k means k pattern bits are matched; every mismatch falls back to "1" or nothing.
  always_comb begin
    cur   = to_legal_state(state_i);
    match = (bit_i == PATTERN[4 - int'(cur)]);
    nxt   = bit_i ? S1 : S0;
    z_o   = 1'b0;
    if (match) begin
      if (cur == S4) begin
        nxt = S3;
        z_o = 1'b1;
      end else begin
        nxt = state_e'(cur + 3'd1);
      end
    end
  end

  assign next_o = nxt;

endmodule

// File: rtl/mealy_ozozo_arbiter.sv
// rtl/mealy_ozozo_arbiter.sv - round-robin time-multiplexed 10101 detector over NCH streams
module mealy_ozozo_arbiter
  import mealy_ozozo_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int CNT_W = 8,
  localparam int CH_W = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NCH-1:0]       req_valid,
  input  logic [NCH-1:0]       req_bit,
  output logic [NCH-1:0]       req_ready,
  input  logic [NCH-1:0]       clear,
  output logic                 res_valid,
  output logic [CH_W-1:0]      res_ch,
  output logic                 res_z,
  output logic [2:0]           res_state,
  output logic [NCH*CNT_W-1:0] hit_cnt
);

  logic [NCH-1:0][2:0]       state_q;
  logic [NCH-1:0][CNT_W-1:0] cnt_q;
  logic [CH_W-1:0]           last_ptr_q;
  logic                      res_valid_q;
  logic [CH_W-1:0]           res_ch_q;
  logic                      res_z_q;
  logic [2:0]                res_state_q;

  logic [NCH-1:0] eligible;
  logic           gnt_found;
  logic [CH_W-1:0] gnt_ch;
  logic [2:0]     step_next;
  logic           step_z;
  int             cand;

  assign eligible = req_valid & ~clear;

  always_comb begin
    gnt_found = 1'b0;
    gnt_ch    = '0;
    cand      = 0;
    for (int k = 1; k <= NCH; k++) begin
      cand = (int'(last_ptr_q) + k) % NCH;
      if (!gnt_found && eligible[cand]) begin
        gnt_found = 1'b1;
        gnt_ch    = CH_W'(cand);
      end
    end
  end

  assign req_ready = gnt_found ? (NCH'(1) << gnt_ch) : '0;

  mealy_ozozo_step u_step (
    .state_i (state_q[gnt_ch]),
    .bit_i   (req_bit[gnt_ch]),
    .next_o  (step_next),
    .z_o     (step_z)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= '0;
      cnt_q       <= '0;
      last_ptr_q  <= CH_W'(NCH - 1);
      res_valid_q <= 1'b0;
      res_ch_q    <= '0;
      res_z_q     <= 1'b0;
      res_state_q <= 3'd0;
    end else begin
      res_valid_q <= gnt_found;
      if (gnt_found) begin
        last_ptr_q      <= gnt_ch;
        res_ch_q        <= gnt_ch;
        res_z_q         <= step_z;
        res_state_q     <= step_next;
        state_q[gnt_ch] <= step_next;
        if (step_z && (cnt_q[gnt_ch] != {CNT_W{1'b1}})) begin
          cnt_q[gnt_ch] <= cnt_q[gnt_ch] + 1'b1;
        end
      end
      // A cleared channel is never granted, so this cannot collide with the write above.
      for (int i = 0; i < NCH; i++) begin
        if (clear[i]) begin
          state_q[i] <= S0;
          cnt_q[i]   <= '0;
        end
      end
    end
  end

  assign res_valid = res_valid_q;
  assign res_ch    = res_ch_q;
  assign res_z     = res_z_q;
  assign res_state = res_state_q;
  assign hit_cnt   = cnt_q;

endmodule

// File: doc/mealy_ozozo_arbiter.md
# mealy_ozozo_arbiter

Time-multiplexes one overlapping "10101" Mealy detection step across NCH independent serial bit streams. Each channel's 3-bit detector state lives in a local state bank. A round-robin arbiter grants one channel per cycle and applies the shared next-state/output step to that channel's bit. The block sits between serial requesters and downstream hit logic, so one detector serves many streams without replicating per-stream FSM logic.

## Interface
- NCH, 4: number of requester channels (2..8)
- CNT_W, 8: width of each per-channel saturating hit counter
- CH_W, $clog2(NCH): channel index width (derived, not overridable)

- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  NCH  channel i presents a bit
- req_bit  in  NCH  serial bit of channel i
- req_ready  out  NCH  one-hot or zero; bit accepted when valid & ready
- clear  in  NCH  synchronous per-channel clear of state and counter
- res_valid  out  1  result of one accepted bit
- res_ch  out  CH_W  channel of that result
- res_z  out  1  Mealy output: 1 when the accepted bit completed "10101"
- res_state  out  3  channel's new state after the step
- hit_cnt  out  NCH*CNT_W  packed counters; channel i at [i*CNT_W +: CNT_W]

## Operation
- Detector states: S0=0 (none), S1=1 ("1"), S2=2 ("10"), S3=3 ("101"), S4=4 ("1010"). Codes 5..7 are illegal and behave as S0.
- Transitions are written bit: next/z.
  - S0: 0: S0/0, 1: S1/0
  - S1: 0: S2/0, 1: S1/0
  - S2: 0: S0/0, 1: S3/0
  - S3: 0: S4/0, 1: S1/0
  - S4: 0: S0/0, 1: S3/1 (overlap retained)
- Arbitration: search starts at channel last_ptr+1, wrapping modulo NCH. The first channel with req_valid=1 and clear=0 is granted.
- req_ready: set for the granted channel only, combinationally from req_valid, clear and last_ptr. All ready bits are 0 when no channel is eligible.
- last_ptr updates to the granted channel only on a transfer. It holds otherwise.
- On a transfer: the state bank entry updates; hit_cnt[ch] increments when z=1 and saturates at 2^CNT_W−1.
- Clear: clear[i] forces state[i]=S0 and hit_cnt[i]=0 at the next edge, and removes channel i from arbitration that cycle. Clear always beats a transfer. Clearing channels other than the granted one does not affect the transfer.

## Timing
- Reset values (asynchronous):
  - all states S0, all hit_cnt 0
  - last_ptr=NCH−1, so channel 0 has first priority
  - res_valid=0, res_ch=0, res_z=0, res_state=0
  - req_ready is combinational and therefore 0 with no valid inputs.
- Latency: a transfer in cycle t produces res_* registered at edge t+1, so they are valid during cycle t+1 only.
- res_valid is a single-cycle pulse per transfer. Other res_* fields hold their last values when res_valid=0.
- hit_cnt and the state bank update at the same edge as res_*.
- Throughput: one bit per cycle total.
- Fairness: each continuously-valid channel is granted at least once every NCH cycles.
- Back-to-back same channel: when only one channel is valid, it is granted every cycle. Its state must chain correctly, with the bank written then read on the next cycle and no bypass hazard.
- Reset mid-stream: all channels return to S0. Partially matched sequences are lost.

## Structure
- Package mealy_ozozo_pkg:
  - state enum S0..S4 (3 bits)
  - constant PATTERN=5'b10101
  - function for the illegal-state mapping
- Sub-module mealy_ozozo_step: purely combinational (state, bit) -> (next, z). It is the shared datapath.
- Top level: round-robin arbiter, NCH×3 state bank, NCH counters, result register.

## Test plan
- Single stream: channel 0 bits 1,0,1,0,1,0,1 with others idle.
  - res_z pulses on the 5th and 7th bits.
  - hit_cnt[0]=2.
  - res_state sequence 1,2,3,4,3,4,3.
- Interleave: all 4 channels valid continuously.
  - Grants in order 0,1,2,3,0,…
  - Ch0 fed 10101 and ch1 fed 11111.
  - Only ch0 hits (res_ch=0, res_z=1, on ch0's 5th grant, cycle 17 relative to start); ch1 stays in S1.
- Fairness/skip: only channels 1 and 3 valid, last_ptr=1.
  - Grant goes to 3, then 1, then 3.
  - req_ready is never set for channels 0 or 2.
- Clear collision: clear[2] asserted while channel 2 is valid and otherwise next in line.
  - No transfer for channel 2 that cycle; the grant passes to the next eligible channel.
  - state[2]=S0 and hit_cnt[2]=0 afterwards.
- Saturation: CNT_W=2, channel 0 fed 1010101010101… until 4 hits.
  - hit_cnt[0] holds at 3.
  - res_z still pulses on the 4th hit.
- Async reset mid-stream: assert reset_n=0 between edges after ch0 reaches S4.
  - Outputs clear immediately.
  - After release, a 1 on ch0 gives res_state=1, res_z=0.
